// File: rtl/three_parallel_crc_retimed.sv
// 3-parallel CRC-5 (g = x^5+x^3+x+1) over 9-bit frames: one load, three
// registered 3-bit groups folded by a 3-step lookahead, one result per 6 clocks.
module three_parallel_crc_retimed (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] data_in,
  output logic [8:0] data_out
);

  typedef enum logic [2:0] {
    PH_LOAD = 3'd0,
    PH_G0   = 3'd1,
    PH_G1   = 3'd2,
    PH_G2   = 3'd3,
    PH_G3   = 3'd4,
    PH_OUT  = 3'd5
  } phase_t;

  localparam logic [4:0] POLY_TAPS = 5'b01011;

  phase_t     phase;
  phase_t     phase_nxt;
  logic [8:0] msg_reg;
  logic [2:0] grp_reg;
  logic [4:0] crc_q;
  logic [4:0] crc_s1;
  logic [4:0] crc_s2;
  logic [4:0] crc_step;

  function automatic logic [4:0] lfsr_step(input logic [4:0] r, input logic b);
    lfsr_step = {r[3:0], 1'b0} ^ ({5{r[4] ^ b}} & POLY_TAPS);
  endfunction

  // Three serial steps chained as one combinational lookahead, MSB of the group first.
  always_comb begin
    crc_s1   = lfsr_step(crc_q,  grp_reg[2]);
    crc_s2   = lfsr_step(crc_s1, grp_reg[1]);
    crc_step = lfsr_step(crc_s2, grp_reg[0]);
  end

  always_comb begin
    phase_nxt = PH_LOAD;
    unique case (phase)
      PH_LOAD: phase_nxt = PH_G0;
      PH_G0:   phase_nxt = PH_G1;
      PH_G1:   phase_nxt = PH_G2;
      PH_G2:   phase_nxt = PH_G3;
      PH_G3:   phase_nxt = PH_OUT;
      PH_OUT:  phase_nxt = PH_LOAD;
      default: phase_nxt = PH_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= PH_LOAD;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Group register runs one phase ahead of the CRC update (retimed input stage).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_reg  <= '0;
      grp_reg  <= '0;
      crc_q    <= '0;
      data_out <= '0;
    end else begin
      unique case (phase)
        PH_LOAD: begin
          msg_reg <= data_in;
          crc_q   <= '0;
        end
        PH_G0: grp_reg <= msg_reg[8:6];
        PH_G1: begin
          grp_reg <= msg_reg[5:3];
          crc_q   <= crc_step;
        end
        PH_G2: begin
          grp_reg <= msg_reg[2:0];
          crc_q   <= crc_step;
        end
        PH_G3:   crc_q    <= crc_step;
        PH_OUT:  data_out <= {4'b0000, crc_q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_three_parallel_crc_retimed.sv
// Directed and random frames for three_parallel_crc_retimed, checked every cycle
// against a polynomial long-division model plus literal expectations.
module tb_three_parallel_crc_retimed;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] data_in;
  logic [8:0] data_out;

  int tests_run = 0;
  int tests_failed = 0;
  bit checking = 1'b0;

  three_parallel_crc_retimed dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Remainder of {w, 5'b0} divided by 101011, done as schoolbook long division.
  function automatic logic [4:0] ref_crc(input logic [8:0] w);
    logic [13:0] v;
    v = {w, 5'b00000};
    for (int i = 13; i >= 5; i--) begin
      if (v[i]) v[i -: 6] = v[i -: 6] ^ 6'b101011;
    end
    return v[4:0];
  endfunction

  // Frame-level model: capture word at frame start, publish its remainder at frame end.
  int         m_pos  = 0;
  logic [8:0] m_word = '0;
  logic [8:0] m_exp  = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos  <= 0;
      m_word <= '0;
      m_exp  <= '0;
    end else begin
      if (m_pos == 0) m_word <= data_in;
      if (m_pos == 5) m_exp <= {4'b0000, ref_crc(m_word)};
      m_pos <= (m_pos == 5) ? 0 : m_pos + 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      tests_run++;
      if (data_out !== m_exp) begin
        tests_failed++;
        $display("FAIL model_cycle t=%0t data_out=%h expected=%h", $time, data_out, m_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    tests_run++;
    if (data_out !== exp) begin
      tests_failed++;
      $display("FAIL %s data_out=%h expected=%h", name, data_out, exp);
    end
  endtask

  task automatic run_frame_check(input string name, input logic [8:0] exp);
    for (int k = 0; k < 5; k++) tick();
    tick();
    check(name, exp);
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 9'b101011010;
    tick();
    tick();
    checking = 1'b1;
    check("reset_state", 9'h000);

    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("first_frame_hold", 9'h000);
    end
    tick();
    check("first_result_6th_edge", 9'h016);
    run_frame_check("repeat_frame", 9'h016);

    // Load edge, then change data_in before the cnt=2 edge
    tick();
    tick();
    data_in = 9'h001;
    for (int k = 0; k < 4; k++) tick();
    check("midframe_change_current", 9'h016);
    run_frame_check("midframe_change_next", 9'h00B);

    data_in = 9'h000;
    run_frame_check("all_zero", 9'h000);
    data_in = 9'b100000000;
    run_frame_check("msb_only", 9'h01F);

    // Abort at cnt=3 with a non-zero result already on the output
    data_in = 9'b101011010;
    tick();
    tick();
    tick();
    check("pre_abort_hold", 9'h01F);
    reset = 1'b0;
    #1;
    check("async_reset_clear", 9'h000);
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("post_abort_hold", 9'h000);
    end
    tick();
    check("post_abort_result", 9'h016);

    for (int f = 0; f < 1000; f++) begin
      data_in = 9'($urandom_range(0, 511));
      tick();
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 1) == 1) data_in = 9'($urandom_range(0, 511));
        tick();
      end
    end
    tick();

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests_run=%0d expected=completion", tests_run);
    $fatal(1, "timeout");
  end

endmodule
